// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// =====================================================================
// dmem_arbiter_if : requester-side and memory-side bus of dmem_arbiter
// Revision: 1.0
// =====================================================================
interface dmem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS-1:0]        lock;
  logic [NUM_MASTERS-1:0]        wen_m;
  logic [NUM_MASTERS*ADDR_W-1:0] addr_m;
  logic [NUM_MASTERS*DATA_W-1:0] wdata_m;
  logic [NUM_MASTERS-1:0]        gnt;
  logic [NUM_MASTERS-1:0]        rvalid;
  logic [DATA_W-1:0]             rdata_m;
  logic [ADDR_W-1:0]             addr_d;
  logic                          wen;
  logic [DATA_W-1:0]             wdata;
  logic [DATA_W-1:0]             rdata;

  // Arbiter side
  modport slave (
    input  req, lock, wen_m, addr_m, wdata_m, rdata,
    output gnt, rvalid, rdata_m, addr_d, wen, wdata
  );

  // Requester/memory-model side
  modport master (
    output req, lock, wen_m, addr_m, wdata_m, rdata,
    input  gnt, rvalid, rdata_m, addr_d, wen, wdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// =====================================================================
// dmem_arbiter : N-master round-robin arbiter for the data-memory port.
// Optional macro DMEM_ARB_PRIO0_EN gives master 0 absolute priority.
// Revision: 1.0
// =====================================================================
module dmem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int c_idx_w  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int c_hold_w = $clog2(MAX_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);
  localparam logic [c_idx_w-1:0]  c_last_rst  = c_idx_w'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_owner;
  logic [c_idx_w-1:0]   w_owner_nxt;
  logic [c_idx_w-1:0]   r_last;
  logic [c_idx_w-1:0]   w_last_nxt;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [c_hold_w-1:0]  w_hold_nxt;

  logic [c_idx_w-1:0]   w_sel;
  logic [c_idx_w-1:0]   w_cand;
  logic                 w_sel_found;
  logic                 w_any_req;
  logic                 w_beat;
  logic                 w_release;

  logic [ADDR_W-1:0]    w_addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]    w_wdata_arr [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = bus.addr_m[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = bus.wdata_m[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_any_req = |bus.req;

  // Round-robin search beginning just after the last owner, wrapping to it.
  always_comb begin
    w_sel       = r_last;
    w_cand      = r_last;
    w_sel_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = c_idx_w'((int'(r_last) + k) % NUM_MASTERS);
      if (!w_sel_found && bus.req[w_cand]) begin
        w_sel       = w_cand;
        w_sel_found = 1'b1;
      end
    end
`ifdef DMEM_ARB_PRIO0_EN
    if (bus.req[0]) begin
      w_sel = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_beat      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_sel;
          w_last_nxt  = w_sel;
          w_hold_nxt  = '0;
        end
      end
      S_OWN: begin
        w_beat    = bus.req[r_owner];
        w_release = !w_beat || !bus.lock[r_owner] ||
                    (w_beat && (r_hold_cnt == c_hold_last));
`ifdef DMEM_ARB_PRIO0_EN
        // An urgent master 0 cuts any other owner short after this beat.
        w_release = w_release || (bus.req[0] && (r_owner != '0));
`endif
        if (w_release) begin
          w_hold_nxt = '0;
          if (w_any_req) begin
            w_owner_nxt = w_sel;
            w_last_nxt  = w_sel;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= c_last_rst;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    bus.wen    = 1'b0;
    bus.addr_d = '0;
    bus.wdata  = '0;
    if (r_state == S_OWN) begin
      bus.gnt[r_owner]    = 1'b1;
      bus.rvalid[r_owner] = bus.req[r_owner] & ~bus.wen_m[r_owner];
      bus.wen             = bus.wen_m[r_owner] & bus.req[r_owner];
      bus.addr_d          = w_addr_arr[r_owner];
      bus.wdata           = w_wdata_arr[r_owner];
    end
  end

  assign bus.rdata_m = bus.rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// =====================================================================
// tb_dmem_arbiter : directed scenarios plus randomized run against a
// behavioural model of the arbitration rules. Revision: 1.0
// =====================================================================
module tb_dmem_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;
`ifdef DMEM_ARB_PRIO0_EN
  localparam int PREEMPT_CYC = 3;
`else
  localparam int PREEMPT_CYC = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [AW-1:0] addr_v  [N];
  logic [DW-1:0] wdata_v [N];

  dmem_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_bus();
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;
    pa = '0;
    pd = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pa = {pa[(N-1)*AW-1:0], addr_v[i]};
      pd = {pd[(N-1)*DW-1:0], wdata_v[i]};
    end
    bus.addr_m  = pa;
    bus.wdata_m = pd;
  endtask

  task automatic clear_inputs();
    bus.req   = '0;
    bus.lock  = '0;
    bus.wen_m = '0;
    bus.rdata = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    apply_bus();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int idx);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    return (v & oh) != '0;
  endfunction

  // First requester after 'last' in circular order (master 0 first when urgent).
  function automatic int pick(input logic [N-1:0] r, input int last);
    int res;
    res = -1;
`ifdef DMEM_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (res < 0 && bit_of(r, (last + k) % N)) res = (last + k) % N;
    end
    return res;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.wen); end
    n_checks++; if (bus.addr_d !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.addr_d); end
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); end
    rst_n = 1'b1;
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    addr_v[0] = 32'h10; addr_v[1] = 32'h20;
    wdata_v[0] = 32'hA0; wdata_v[1] = 32'hB0;
    apply_bus();
    bus.req = 2'b11; bus.lock = 2'b00; bus.wen_m = 2'b10;
    tick();
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rr_c1_gnt: got %b want 01", bus.gnt); end
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL rr_c1_wen: got %b want 0", bus.wen); end
    n_checks++; if (bus.addr_d !== 32'h10) begin n_fail++; $display("FAIL rr_c1_addr: got %h want 10", bus.addr_d); end
    tick();
    n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL rr_c2_gnt: got %b want 10", bus.gnt); end
    n_checks++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL rr_c2_wen: got %b want 1", bus.wen); end
    n_checks++; if (bus.addr_d !== 32'h20) begin n_fail++; $display("FAIL rr_c2_addr: got %h want 20", bus.addr_d); end
    n_checks++; if (bus.wdata !== 32'hB0) begin n_fail++; $display("FAIL rr_c2_wdata: got %h want b0", bus.wdata); end
    tick();
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rr_c3_gnt: got %b want 01", bus.gnt); end
    n_checks++; if (bus.addr_d !== 32'h10) begin n_fail++; $display("FAIL rr_c3_addr: got %h want 10", bus.addr_d); end
    bus.req = 2'b00;
    tick();
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gnt: got %b want 00", bus.gnt); end
  endtask

  task automatic test_locked_burst();
    do_reset();
    bus.req = 2'b10; bus.lock = 2'b10; bus.wen_m = 2'b10;
    for (int b = 0; b < 4; b++) begin
      addr_v[1] = 32'h100 + 32'(4 * b);
      wdata_v[1] = 32'(b + 1);
      apply_bus();
      tick();
      n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL burst_b%0d_gnt: got %b want 10", b, bus.gnt); end
      n_checks++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL burst_b%0d_wen: got %b want 1", b, bus.wen); end
      n_checks++; if (bus.addr_d !== 32'h100 + 32'(4 * b)) begin n_fail++; $display("FAIL burst_b%0d_addr: got %h want %h", b, bus.addr_d, 32'h100 + 32'(4 * b)); end
    end
    // Sole requester is regranted at the hold release; dropping req idles the port.
    bus.req = 2'b00;
    #1;
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL burst_drop_wen: got %b want 0", bus.wen); end
    tick();
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL burst_end_gnt: got %b want 00", bus.gnt); end
    n_checks++; if (bus.addr_d !== '0) begin n_fail++; $display("FAIL burst_end_addr: got %h want 0", bus.addr_d); end
  endtask

  task automatic test_prio_preempt();
    logic [1:0] exp_gnt;
    do_reset();
    addr_v[0] = 32'h40;
    bus.req = 2'b10; bus.lock = 2'b10; bus.wen_m = 2'b10;
    for (int c = 1; c <= PREEMPT_CYC; c++) begin
      addr_v[1] = 32'h100 + 32'(4 * (c - 1));
      apply_bus();
      tick();
      exp_gnt = (c < PREEMPT_CYC) ? 2'b10 : 2'b01;
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL prio_c%0d_gnt: got %b want %b", c, bus.gnt, exp_gnt); end
      if (c == 2) bus.req[0] = 1'b1;
    end
    n_checks++; if (bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL prio_m0_rvalid: got %b want 01", bus.rvalid); end
    n_checks++; if (bus.addr_d !== 32'h40) begin n_fail++; $display("FAIL prio_m0_addr: got %h want 40", bus.addr_d); end
    bus.req[0] = 1'b0;
    tick();
    n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL prio_resume_gnt: got %b want 10", bus.gnt); end
    bus.req = 2'b00;
    tick();
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL prio_idle_gnt: got %b want 00", bus.gnt); end
  endtask

  task automatic test_read();
    do_reset();
    bus.req = 2'b01; bus.wen_m = 2'b00; bus.rdata = 32'hDEADBEEF;
    tick();
    n_checks++; if (bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL read_rvalid: got %b want 01", bus.rvalid); end
    n_checks++; if (bus.rdata_m !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h want deadbeef", bus.rdata_m); end
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL read_wen: got %b want 0", bus.wen); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    addr_v[0] = 32'h200; addr_v[1] = 32'h300;
    apply_bus();
    bus.req = 2'b11; bus.lock = 2'b11; bus.wen_m = 2'b11;
    tick();
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL drop_c1_gnt: got %b want 01", bus.gnt); end
    n_checks++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL drop_c1_wen: got %b want 1", bus.wen); end
    bus.req = 2'b10;
    #1;
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL drop_c2_wen: got %b want 0", bus.wen); end
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL drop_c2_gnt: got %b want 01", bus.gnt); end
    tick();
    n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL drop_hand_gnt: got %b want 10", bus.gnt); end
    n_checks++; if (bus.addr_d !== 32'h300) begin n_fail++; $display("FAIL drop_hand_addr: got %h want 300", bus.addr_d); end
    bus.req = 2'b00;
    #1;
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL drop_c3_rvalid: got %b want 00", bus.rvalid); end
    tick();
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL drop_idle_gnt: got %b want 00", bus.gnt); end
    n_checks++; if (bus.wdata !== '0) begin n_fail++; $display("FAIL drop_idle_wdata: got %h want 0", bus.wdata); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    addr_v[1] = 32'h100;
    apply_bus();
    bus.req = 2'b10; bus.lock = 2'b10; bus.wen_m = 2'b10;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    bus.req = 2'b11;
    #1;
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 00", bus.gnt); end
    n_checks++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen: got %b want 0", bus.wen); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_gnt: got %b want 01", bus.gnt); end
  endtask

  task automatic test_random();
    int m_owner, m_last, m_beats;
    logic beat, rel;
    logic [N-1:0] exp_gnt, exp_rv;
    logic exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    do_reset();
    m_owner = -1; m_last = N - 1; m_beats = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        addr_v[i]  = $urandom;
        wdata_v[i] = $urandom;
      end
      apply_bus();
      for (int i = 0; i < N; i++) begin
        bus.req[i]   = ($urandom_range(0, 3) != 0);
        bus.lock[i]  = ($urandom_range(0, 3) != 0);
        bus.wen_m[i] = $urandom_range(0, 1) != 0;
      end
      bus.rdata = $urandom;
      #1;
      exp_gnt = '0; exp_rv = '0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
      if (m_owner >= 0) begin
        exp_gnt   = N'(1) << m_owner;
        exp_wen   = bit_of(bus.req, m_owner) && bit_of(bus.wen_m, m_owner);
        exp_rv    = (bit_of(bus.req, m_owner) && !bit_of(bus.wen_m, m_owner)) ? exp_gnt : '0;
        exp_addr  = addr_v[m_owner];
        exp_wdata = wdata_v[m_owner];
      end
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rand%0d_gnt: got %b want %b", cyc, bus.gnt, exp_gnt); end
      n_checks++; if (bus.rvalid !== exp_rv) begin n_fail++; $display("FAIL rand%0d_rvalid: got %b want %b", cyc, bus.rvalid, exp_rv); end
      n_checks++; if (bus.wen !== exp_wen) begin n_fail++; $display("FAIL rand%0d_wen: got %b want %b", cyc, bus.wen, exp_wen); end
      n_checks++; if (bus.addr_d !== exp_addr) begin n_fail++; $display("FAIL rand%0d_addr: got %h want %h", cyc, bus.addr_d, exp_addr); end
      n_checks++; if (bus.wdata !== exp_wdata) begin n_fail++; $display("FAIL rand%0d_wdata: got %h want %h", cyc, bus.wdata, exp_wdata); end
      if (m_owner < 0) begin
        if (bus.req != '0) begin
          m_owner = pick(bus.req, m_last); m_last = m_owner; m_beats = 0;
        end
      end else begin
        beat = bit_of(bus.req, m_owner);
        if (beat) m_beats++;
        rel = !beat || !bit_of(bus.lock, m_owner) || (m_beats == MH);
`ifdef DMEM_ARB_PRIO0_EN
        rel = rel || (bus.req[0] && m_owner != 0);
`endif
        if (rel) begin
          if (bus.req != '0) begin
            m_owner = pick(bus.req, m_last); m_last = m_owner; m_beats = 0;
          end else begin
            m_owner = -1;
          end
        end
      end
      tick();
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_locked_burst();
    test_prio_preempt();
    test_read();
    test_drop();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised N-master arbiter for the single data-memory port (addr/wen/wdata/rdata) of `memory`. It sits in `top` between the requesters (core, uart, future DMA) and `memory`, and replaces the fixed two-way `intr` mux. It adds:
- registered round-robin grants;
- optional locked multi-beat ownership with a bounded hold;
- per-master read-valid returns.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); master index 0 is the urgent master (uart).
- ADDR_W, 32, address width (matches WORD_LEN).
- DATA_W, 32, data width (matches WORD_LEN).
- MAX_HOLD, 4, maximum consecutive beats per grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_MASTERS  per-master access request.
- lock  in  NUM_MASTERS  per-master request to keep ownership for further beats.
- wen_m  in  NUM_MASTERS  per-master write enable.
- addr_m  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies [i*ADDR_W +: ADDR_W].
- wdata_m  in  NUM_MASTERS*DATA_W  per-master write data, same packing.
- gnt  out  NUM_MASTERS  one-hot ownership indication.
- rvalid  out  NUM_MASTERS  rdata is valid for master i this cycle.
- rdata_m  out  DATA_W  read data broadcast to all masters (= rdata).
- addr_d  out  ADDR_W  memory address.
- wen  out  1  memory write enable.
- wdata  out  DATA_W  memory write data.
- rdata  in  DATA_W  memory read data (combinational read, same cycle).

## Operation
- State machine with two states.
  - IDLE: no owner.
  - OWN: owner register valid.
- Registered state:
  - owner index;
  - last-owner pointer `last`;
  - beat counter `hold_cnt`, width clog2(MAX_HOLD+1).
- Selection function (used at every grant edge):
  - Search req starting at last+1 and wrapping, ending at last.
  - The first set bit wins.
- IDLE:
  - If any req is set, select at the clock edge, go to OWN, set last=owner, clear hold_cnt.
  - Otherwise stay in IDLE.
- OWN, outputs:
  - gnt[owner]=1.
  - addr_d, wdata and wen are taken from master `owner`.
  - wen = wen_m[owner] & req[owner].
- OWN, beats:
  - A cycle with req[owner]=1 is a beat.
  - On each beat, hold_cnt increments.
  - rvalid[owner] = req[owner] & ~wen_m[owner].
- Release occurs at the edge ending a cycle in which any of these holds:
  - req[owner]=0; or
  - lock[owner]=0; or
  - the cycle is a beat with hold_cnt==MAX_HOLD-1.
- Behaviour at release:
  - If any req is set, select the next owner at the same edge. There is no bubble.
  - The current owner can be reselected only if no other master requests.
  - If no req is set, go to IDLE.
- IDLE outputs: gnt=0, rvalid=0, wen=0, addr_d=0, wdata=0.
- Handshake rules:
  - A master holds req and its addr/wdata/wen stable until it sees gnt.
  - A transfer completes in every cycle in which gnt[i] & req[i].
  - Dropping req while granted wastes that cycle (no write) and releases ownership.
- Outputs derived from state are registered. Data-path outputs are muxed combinationally from the owner inputs.

## Timing
- Reset (async, rst_n=0):
  - State goes to IDLE and gnt=0.
  - last=NUM_MASTERS-1, so master 0 wins the first arbitration.
  - hold_cnt=0.
  - All memory-side outputs are 0.
- Latency:
  - A req sampled high in IDLE at edge t gives gnt from cycle t+1.
  - The first beat occurs in cycle t+1.
- Unlocked request: exactly one beat per grant.
- Locked request: up to MAX_HOLD consecutive beats.
- Handover: the cycle after the last beat of one owner can be the first beat of the next owner.
- Reset asserted mid-burst: the in-flight write is not guaranteed. gnt deasserts immediately (asynchronously).
- Simultaneous request and release by the same master: the master is reselected only if no other req is set.

## Configuration
- DMEM_ARB_PRIO0_EN defined:
  - Master 0 wins every selection whenever req[0]=1.
  - A locked owner other than master 0 is released at the end of its current beat whenever req[0]=1. Master 0 then takes the port with no bubble.
- DMEM_ARB_PRIO0_EN undefined: pure round-robin; master 0 waits like any other master.

## Test plan
- Reset, then req=2'b11 with no lock: gnt=01 in cycle 1, then 10 in cycle 2, then 01 in cycle 3; wen and addr follow the owner each cycle.
- Master 1 locked, writing addr 0x100..0x10C, MAX_HOLD=4, master 0 idle: four consecutive beats with wen=1; release after the 4th beat; gnt=0 in the next cycle.
- Same burst as above with req[0] rising at beat 2:
  - Macro undefined: master 0 is granted in the cycle after beat 4.
  - Macro defined: master 0 is granted in the cycle after beat 2.
- Read by master 0 with rdata=0xDEADBEEF: rvalid[0]=1, rdata_m=0xDEADBEEF, wen=0; rvalid[1]=0.
- Granted master drops req: that cycle wen=0 and no rvalid; the next edge hands the port to the other requester, or goes to IDLE with all outputs 0.
- rst_n pulsed low mid-burst: gnt=0 and wen=0 asynchronously; after release, master 0 wins the first arbitration.
